// File: rtl/afbc_tile_arbiter_if.sv
// Tile requester, compressor and result handshake bundle for afbc_tile_arbiter.
// master = arbiter side, slave = surrounding crossbar/compressor/consumer side.
interface afbc_tile_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TILE_BITS = 4096,
    parameter int unsigned CMP_BITS  = 1024
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*TILE_BITS-1:0] req_pixels;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         blk_valid;
    logic [TILE_BITS-1:0]         blk_pixels;
    logic                         blk_ready;
    logic                         cmp_valid;
    logic [CMP_BITS-1:0]          cmp_data;
    logic                         cmp_ready;
    logic                         out_valid;
    logic [CMP_BITS-1:0]          out_data;
    logic [IDW-1:0]               out_id;
    logic                         out_ready;

    modport master (
        input  req_valid, req_pixels, blk_ready, cmp_valid, cmp_data, out_ready,
        output req_ready, blk_valid, blk_pixels, cmp_ready, out_valid, out_data, out_id
    );

    modport slave (
        output req_valid, req_pixels, blk_ready, cmp_valid, cmp_data, out_ready,
        input  req_ready, blk_valid, blk_pixels, cmp_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/afbc_tile_arbiter.sv
// Round-robin arbiter sharing one AFBC compressor between NUM_REQ tile producers.
// Optional watchdog on stuck tiles enabled by defining AFBC_ARB_WATCHDOG_EN.
module afbc_tile_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TILE_BITS   = 4096,
    parameter int unsigned CMP_BITS    = 1024,
    parameter int unsigned WDOG_CYCLES = 1024,
    localparam int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    afbc_tile_arbiter_if.master   bus,
    output logic [31:0]           perf_grants,
    output logic [31:0]           perf_busy,
    output logic                  err_timeout,
    output logic [IDW-1:0]        err_id
);

    typedef enum logic [1:0] {StArb, StSend, StWait, StDrain} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CMP_BITS-1:0] out_data_q, out_data_d;
    logic [31:0]         perf_grants_q, perf_grants_d;
    logic [31:0]         perf_busy_q, perf_busy_d;
    logic                found;
    logic [IDW-1:0]      pick;
    logic [IDW-1:0]      scan_idx;
    logic                timeout;

    if (WDOG_CYCLES == 0) begin : g_bad_wdog
        $error("WDOG_CYCLES must be non-zero");
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (!found && bus.req_valid[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        out_data_d     = out_data_q;
        perf_grants_d  = perf_grants_q;
        perf_busy_d    = (state_q != StArb) ? perf_busy_q + 32'd1 : perf_busy_q;
        bus.req_ready  = '0;
        bus.blk_valid  = 1'b0;
        bus.blk_pixels = '0;
        bus.cmp_ready  = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_id     = '0;
        unique case (state_q)
            StArb: begin
                if (found) begin
                    state_d       = StSend;
                    grant_d       = pick;
                    rr_ptr_d      = (32'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
                    perf_grants_d = perf_grants_q + 32'd1;
                end
            end
            StSend: begin
                bus.blk_valid = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IDW'(i)) bus.blk_pixels = bus.req_pixels[i*TILE_BITS +: TILE_BITS];
                end
                if (timeout) begin
                    state_d = StArb;
                end else if (bus.blk_ready) begin
                    bus.req_ready[grant_q] = 1'b1;
                    state_d                = StWait;
                end
            end
            StWait: begin
                if (timeout) begin
                    state_d = StArb;
                end else begin
                    bus.cmp_ready = 1'b1;
                    if (bus.cmp_valid) begin
                        out_data_d = bus.cmp_data;
                        state_d    = StDrain;
                    end
                end
            end
            StDrain: begin
                bus.out_valid = 1'b1;
                bus.out_id    = grant_q;
                if (bus.out_ready) state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StArb;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            out_data_q    <= '0;
            perf_grants_q <= '0;
            perf_busy_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            out_data_q    <= out_data_d;
            perf_grants_q <= perf_grants_d;
            perf_busy_q   <= perf_busy_d;
        end
    end

    assign bus.out_data = out_data_q;
    assign perf_grants  = perf_grants_q;
    assign perf_busy    = perf_busy_q;

`ifdef AFBC_ARB_WATCHDOG_EN
    logic [31:0]    wdog_q, wdog_d;
    logic [IDW-1:0] err_id_q;

    // Held at zero in ARB so it reads 0 on the first SEND cycle.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == StArb) wdog_d = '0;
        else if (state_q == StSend || state_q == StWait) wdog_d = wdog_q + 32'd1;
    end

    assign timeout     = (state_q == StSend || state_q == StWait) && (wdog_q == WDOG_CYCLES);
    assign err_timeout = timeout;
    assign err_id      = timeout ? grant_q : err_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q   <= '0;
            err_id_q <= '0;
        end else begin
            wdog_q   <= wdog_d;
            if (timeout) err_id_q <= grant_q;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
    assign err_id      = '0;
`endif

endmodule

// File: tb/tb_afbc_tile_arbiter.sv
// Self-checking bench for afbc_tile_arbiter: directed scenarios plus randomized tiles
// checked against a transaction-level round-robin model.
module tb_afbc_tile_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned TBW = 32;
    localparam int unsigned CBW = 32;
    localparam int unsigned WD  = 16;
    localparam int unsigned IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    perf_grants, perf_busy;
    logic           err_timeout;
    logic [IDW-1:0] err_id;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model state
    int          m_rr     = 0;
    logic [31:0] m_grants = 0;
    logic [31:0] m_busy   = 0;
    logic [TBW-1:0] tiles [N];

    afbc_tile_arbiter_if #(.NUM_REQ(N), .TILE_BITS(TBW), .CMP_BITS(CBW)) bus ();

    afbc_tile_arbiter #(
        .NUM_REQ(N), .TILE_BITS(TBW), .CMP_BITS(CBW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_grants(perf_grants), .perf_busy(perf_busy),
        .err_timeout(err_timeout), .err_id(err_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic load_tiles();
        for (int i = 0; i < N; i++) begin
            tiles[i] = $urandom;
            bus.req_pixels[i*TBW +: TBW] = tiles[i];
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_grants = 0;
        m_busy = 0;
    endtask

    // One full tile: grant, optional SEND stall, compressor latency, optional DRAIN stall.
    task automatic do_tile(input int blk_stall, input int cmp_delay, input int out_stall,
                           input logic [CBW-1:0] cdata, input bit drop_after);
        int g;
        int waited;
        logic [N-1:0] exp_rdy;
        g = pick(bus.req_valid, m_rr);
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        waited = 0;
        while (bus.blk_valid !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        n_cmp++;
        if (bus.blk_valid !== 1'b1) begin
            n_err++;
            $display("FAIL grant_wait: blk_valid=%b after %0d cycles, required 1", bus.blk_valid, waited);
            return;
        end
        m_grants++;
        m_rr = (g + 1) % N;
        for (int s = 0; s < blk_stall; s++) begin
            bus.cmp_valid = 1'b1;
            bus.cmp_data  = ~cdata;
            #1;
            n_cmp++;
            if (bus.blk_valid !== 1'b1 || bus.blk_pixels !== tiles[g] || bus.req_ready !== '0) begin
                n_err++;
                $display("FAIL send_hold: blk_valid=%b pixels=%h req_ready=%b, required 1 %h 0000",
                         bus.blk_valid, bus.blk_pixels, bus.req_ready, tiles[g]);
            end
            step();
        end
        bus.cmp_valid = 1'b0;
        bus.blk_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== exp_rdy || bus.blk_pixels !== tiles[g]) begin
            n_err++;
            $display("FAIL send_accept: req_ready=%b pixels=%h, required %b %h",
                     bus.req_ready, bus.blk_pixels, exp_rdy, tiles[g]);
        end
        step();
        bus.blk_ready = 1'b0;
        if (drop_after) bus.req_valid[g] = 1'b0;
        m_busy += 32'(blk_stall + 1);
        #1;
        n_cmp++;
        if (bus.cmp_ready !== 1'b1 || bus.req_ready !== '0 || bus.blk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_entry: cmp_ready=%b req_ready=%b blk_valid=%b, required 1 0000 0",
                     bus.cmp_ready, bus.req_ready, bus.blk_valid);
        end
        for (int c = 0; c < cmp_delay; c++) step();
        bus.cmp_valid = 1'b1;
        bus.cmp_data  = cdata;
        step();
        bus.cmp_valid = 1'b0;
        m_busy += 32'(cmp_delay + 1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== IDW'(g) || bus.out_data !== cdata ||
            bus.cmp_ready !== 1'b0) begin
            n_err++;
            $display("FAIL drain: valid=%b id=%0d data=%h cmp_ready=%b, required 1 %0d %h 0",
                     bus.out_valid, bus.out_id, bus.out_data, bus.cmp_ready, g, cdata);
        end
        for (int o = 0; o < out_stall; o++) begin
            bus.cmp_valid = 1'b1;
            bus.cmp_data  = cdata ^ 32'h5A5A_0F0F;
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== cdata || bus.blk_valid !== 1'b0) begin
                n_err++;
                $display("FAIL drain_hold: valid=%b data=%h blk_valid=%b, required 1 %h 0",
                         bus.out_valid, bus.out_data, bus.blk_valid, cdata);
            end
        end
        bus.cmp_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        m_busy += 32'(out_stall + 1);
        n_cmp++;
        if (bus.blk_valid !== 1'b0 || bus.out_valid !== 1'b0 || perf_grants !== m_grants ||
            perf_busy !== m_busy) begin
            n_err++;
            $display("FAIL bubble: blk_valid=%b out_valid=%b grants=%0d busy=%0d, required 0 0 %0d %0d",
                     bus.blk_valid, bus.out_valid, perf_grants, perf_busy, m_grants, m_busy);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (bus.blk_valid !== 1'b0 || bus.blk_pixels !== '0 || bus.req_ready !== '0 ||
            bus.cmp_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_id !== '0 || perf_grants !== '0 || perf_busy !== '0 ||
            err_timeout !== 1'b0 || err_id !== '0) begin
            n_err++;
            $display("FAIL %s: blk=%b pix=%h rdy=%b cmp_rdy=%b ov=%b od=%h id=%0d pg=%0d pb=%0d et=%b eid=%0d, required all 0",
                     name, bus.blk_valid, bus.blk_pixels, bus.req_ready, bus.cmp_ready,
                     bus.out_valid, bus.out_data, bus.out_id, perf_grants, perf_busy,
                     err_timeout, err_id);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_zero("reset_state");
        rst = 1'b0;
        step();
        step();
        check_zero("idle_after_reset");
        model_reset();
    endtask

    task automatic test_round_robin();
        load_tiles();
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) do_tile(0, 3, 0, $urandom, 1'b0);
        bus.req_valid = '0;
        n_cmp++;
        if (perf_grants !== 32'd5) begin
            n_err++;
            $display("FAIL rr_grants: perf_grants=%0d, required 5", perf_grants);
        end
    endtask

    task automatic test_wrap();
        bus.req_valid = 4'b0100;
        do_tile(1, 0, 0, $urandom, 1'b0);
        do_tile(1, 2, 0, $urandom, 1'b0);
        bus.req_valid = '0;
    endtask

    task automatic test_blk_stall();
        load_tiles();
        bus.req_valid = 4'b0011;
        do_tile(10, 1, 0, $urandom, 1'b1);
        bus.req_valid = '0;
    endtask

    task automatic test_drain_hold();
        bus.req_valid = 4'b1000;
        do_tile(0, 2, 5, 32'hA5A5_A5A5, 1'b1);
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        int waited;
        bus.req_valid = 4'b1000;
        waited = 0;
        while (bus.blk_valid !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        bus.blk_ready = 1'b1;
        step();
        bus.blk_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("reset_in_wait");
        step();
        rst = 1'b0;
        model_reset();
        load_tiles();
        bus.req_valid = 4'b1010;
        do_tile(0, 1, 0, $urandom, 1'b0);
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            load_tiles();
            bus.req_valid = N'($urandom_range(1, (1 << N) - 1));
            do_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), $urandom, 1'b0);
        end
        bus.req_valid = '0;
    endtask

`ifdef AFBC_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int g;
        int cnt;
        bus.req_valid = 4'b0110;
        g = pick(bus.req_valid, m_rr);
        cnt = 0;
        while (bus.blk_valid !== 1'b1 && cnt < 8) begin
            step();
            cnt++;
        end
        m_grants++;
        m_rr = (g + 1) % N;
        bus.blk_ready = 1'b1;
        step();
        bus.blk_ready = 1'b0;
        bus.req_valid = '0;
        cnt = 1;
        while (err_timeout !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt != int'(WD) || err_id !== IDW'(g)) begin
            n_err++;
            $display("FAIL wdog_pulse: at cycle %0d err_id=%0d, required cycle %0d id %0d",
                     cnt, err_id, WD, g);
        end
        step();
        m_busy += 32'(WD + 1);
        n_cmp++;
        if (err_timeout !== 1'b0 || err_id !== IDW'(g) || bus.blk_valid !== 1'b0 ||
            bus.cmp_ready !== 1'b0 || perf_busy !== m_busy || perf_grants !== m_grants) begin
            n_err++;
            $display("FAIL wdog_after: et=%b id=%0d blk=%b crdy=%b busy=%0d grants=%0d, required 0 %0d 0 0 %0d %0d",
                     err_timeout, err_id, bus.blk_valid, bus.cmp_ready, perf_busy, perf_grants,
                     g, m_busy, m_grants);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_pixels = '0;
        bus.blk_ready  = 1'b0;
        bus.cmp_valid  = 1'b0;
        bus.cmp_data   = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap();
        test_blk_stall();
        test_drain_hold();
        test_reset_midflight();
        test_random();
`ifdef AFBC_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end
endmodule
